// File: rtl/dma_seq_pkg.sv
// Shared types and codes for the DMA transfer sequencer.
// Compile with DMA_COMPRESSED_TIMING_EN defined to honour CmdCompressed.
package dma_seq_pkg;

  typedef enum logic [2:0] {
    SI_IDX = 3'd0,
    S0_IDX = 3'd1,
    S1_IDX = 3'd2,
    S2_IDX = 3'd3,
    S3_IDX = 3'd4,
    S4_IDX = 3'd5
  } state_idx_e;

  typedef enum logic [5:0] {
    ST_SI = 6'b000001,
    ST_S0 = 6'b000010,
    ST_S1 = 6'b000100,
    ST_S2 = 6'b001000,
    ST_S3 = 6'b010000,
    ST_S4 = 6'b100000
  } state_e;

  localparam logic [1:0] VERIFY    = 2'b00;
  localparam logic [1:0] DMA_WRITE = 2'b01;
  localparam logic [1:0] DMA_READ  = 2'b10;

  localparam logic [1:0] DEMAND = 2'b00;
  localparam logic [1:0] SINGLE = 2'b01;
  localparam logic [1:0] BLOCK  = 2'b10;

  // True when the stepped address has just carried into the upper byte.
  function automatic logic low_byte_wraps(input logic [7:0] low_byte, input logic decr);
    return decr ? (low_byte == 8'hFF) : (low_byte == 8'h00);
  endfunction

endpackage

// File: rtl/dma_addr_count_unit.sv
// Working address (TAR) and word count (TWC) for the active channel,
// with step logic, terminal-count and upper-byte-change detection.
module dma_addr_count_unit
  import dma_seq_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              load,
  input  logic              step,
  input  logic              decr,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [CNT_W-1:0]  load_count,
  output logic [ADDR_W-1:0] tar_q,
  output logic [ADDR_W-1:0] tar_d,
  output logic [CNT_W-1:0]  twc_q,
  output logic              twc_zero,
  output logic              page_cross
);

  logic [ADDR_W-1:0] tar_step;
  logic [CNT_W-1:0]  twc_d;

  always_comb begin
    tar_step   = decr ? (tar_q - ADDR_W'(1)) : (tar_q + ADDR_W'(1));
    page_cross = low_byte_wraps(tar_step[7:0], decr);
    twc_zero   = (twc_q == '0);
    tar_d      = tar_q;
    twc_d      = twc_q;
    if (load) begin
      tar_d = load_addr;
      twc_d = load_count;
    end else if (step) begin
      tar_d = tar_step;
      twc_d = twc_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      tar_q <= '0;
      twc_q <= '0;
    end else begin
      tar_q <= tar_d;
      twc_q <= twc_d;
    end
  end

endmodule

// File: rtl/dma_xfer_sequencer.sv
// DMA transfer sequencer: SI/S0..S4 one-hot FSM, strobe decode and writeback.
// Optional feature macro: DMA_COMPRESSED_TIMING_EN (S2 goes straight to S4).
module dma_xfer_sequencer
  import dma_seq_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      ReqValid,
  input  logic [$clog2(NUM_CH)-1:0] ReqID,
  input  logic [NUM_CH-1:0]         DReq,
  input  logic [NUM_CH*ADDR_W-1:0]  CurAddr,
  input  logic [NUM_CH*CNT_W-1:0]   CurCount,
  input  logic [2*NUM_CH-1:0]       ModeDir,
  input  logic [2*NUM_CH-1:0]       ModeXfer,
  input  logic [NUM_CH-1:0]         ModeDecr,
  input  logic                      CmdCompressed,
  input  logic                      Hlda,
  input  logic                      Ready,
  input  logic                      nEopIn,
  output logic                      Hrq,
  output logic                      Aen,
  output logic                      Adstb,
  output logic [ADDR_W-1:0]         Addr,
  output logic                      nIOR,
  output logic                      nIOW,
  output logic                      nMEMR,
  output logic                      nMEMW,
  output logic                      nEopOut,
  output logic                      WbValid,
  output logic [$clog2(NUM_CH)-1:0] WbID,
  output logic [ADDR_W-1:0]         WbAddr,
  output logic [CNT_W-1:0]          WbCount,
  output logic                      WbTC
);

  localparam int ID_W = $clog2(NUM_CH);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   act_id_q, act_id_d;
  logic              eop_q, eop_d, wb_valid_q, wb_valid_d, wb_tc_q, wb_tc_d;
  logic              hrq_q, hrq_d, aen_q, aen_d, adstb_q, adstb_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              nior_q, nior_d, niow_q, niow_d, nmemr_q, nmemr_d, nmemw_q, nmemw_d;
  logic              neop_q, neop_d;

  logic              load, step, twc_zero, page_cross, compressed, start, in_xfer, eop_seen;
  logic              rd_act, wr_act, decr_ch, dreq_ch;
  logic [1:0]        dir_ch, xfer_ch;
  logic [ADDR_W-1:0] tar_q, tar_d;
  logic [CNT_W-1:0]  twc_q;

`ifdef DMA_COMPRESSED_TIMING_EN
  assign compressed = CmdCompressed;
`else
  logic unused_cmd_compressed;
  assign unused_cmd_compressed = CmdCompressed;
  assign compressed            = 1'b0;
`endif

  assign dir_ch  = ModeDir[act_id_q*2 +: 2];
  assign xfer_ch = ModeXfer[act_id_q*2 +: 2];
  assign decr_ch = ModeDecr[act_id_q];
  assign dreq_ch = DReq[act_id_q];
  assign start   = (state_q == ST_SI) && ReqValid && !wb_valid_q;
  assign load    = start;
  assign in_xfer = state_q[S1_IDX] | state_q[S2_IDX] | state_q[S3_IDX] | state_q[S4_IDX];
  assign eop_seen = eop_q || !nEopIn;

  dma_addr_count_unit #(
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) u_addr_count (
    .clk       (Clock),
    .srst      (Reset),
    .load      (load),
    .step      (step),
    .decr      (decr_ch),
    .load_addr (CurAddr[ReqID*ADDR_W +: ADDR_W]),
    .load_count(CurCount[ReqID*CNT_W +: CNT_W]),
    .tar_q     (tar_q),
    .tar_d     (tar_d),
    .twc_q     (twc_q),
    .twc_zero  (twc_zero),
    .page_cross(page_cross)
  );

  always_comb begin
    state_d    = state_q;
    act_id_d   = act_id_q;
    eop_d      = eop_q;
    wb_tc_d    = wb_tc_q;
    wb_valid_d = 1'b0;
    step       = 1'b0;
    if (in_xfer && !nEopIn) eop_d = 1'b1;
    case (state_q)
      ST_SI: begin
        eop_d = 1'b0;
        if (start) begin
          act_id_d = ReqID;
          state_d  = ST_S0;
        end
      end
      ST_S0: begin
        if (Hlda) begin
          state_d = ST_S1;
        end else if (!nEopIn) begin
          state_d    = ST_SI;
          wb_valid_d = 1'b1;
          wb_tc_d    = 1'b0;
        end
      end
      ST_S1: state_d = ST_S2;
      ST_S2: begin
        if (!compressed)  state_d = ST_S3;
        else if (Ready)   state_d = ST_S4;
      end
      ST_S3: if (Ready) state_d = ST_S4;
      ST_S4: begin
        step    = 1'b1;
        wb_tc_d = twc_zero;
        if (twc_zero || eop_seen || xfer_ch == SINGLE || xfer_ch == 2'b11 ||
            (xfer_ch == DEMAND && !dreq_ch)) begin
          state_d    = ST_SI;
          wb_valid_d = 1'b1;
        end else if (page_cross) begin
          state_d = ST_S1;
        end else begin
          state_d = ST_S2;
        end
      end
      default: state_d = ST_SI;
    endcase
    // Losing the bus abandons the transfer; TAR/TWC stay as they were.
    if (in_xfer && !Hlda) begin
      state_d    = ST_SI;
      step       = 1'b0;
      wb_valid_d = 1'b1;
      wb_tc_d    = 1'b0;
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    rd_act  = (state_d == ST_S2) || (state_d == ST_S3);
    wr_act  = (state_d == ST_S3);
    hrq_d   = (state_d != ST_SI);
    aen_d   = (state_d == ST_S1) || rd_act || (state_d == ST_S4);
    adstb_d = (state_d == ST_S1);
    addr_d  = aen_d ? tar_d : '0;
    nior_d  = !(rd_act && dir_ch == DMA_WRITE);
    nmemr_d = !(rd_act && dir_ch == DMA_READ);
    nmemw_d = !(wr_act && dir_ch == DMA_WRITE);
    niow_d  = !(wr_act && dir_ch == DMA_READ);
    neop_d  = !((state_d == ST_S4) && twc_zero);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= ST_SI;
      act_id_q   <= '0;
      eop_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_tc_q    <= 1'b0;
      hrq_q      <= 1'b0;
      aen_q      <= 1'b0;
      adstb_q    <= 1'b0;
      addr_q     <= '0;
      nior_q     <= 1'b1;
      niow_q     <= 1'b1;
      nmemr_q    <= 1'b1;
      nmemw_q    <= 1'b1;
      neop_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      act_id_q   <= act_id_d;
      eop_q      <= eop_d;
      wb_valid_q <= wb_valid_d;
      wb_tc_q    <= wb_tc_d;
      hrq_q      <= hrq_d;
      aen_q      <= aen_d;
      adstb_q    <= adstb_d;
      addr_q     <= addr_d;
      nior_q     <= nior_d;
      niow_q     <= niow_d;
      nmemr_q    <= nmemr_d;
      nmemw_q    <= nmemw_d;
      neop_q     <= neop_d;
    end
  end

  assign Hrq     = hrq_q;
  assign Aen     = aen_q;
  assign Adstb   = adstb_q;
  assign Addr    = addr_q;
  assign nIOR    = nior_q;
  assign nIOW    = niow_q;
  assign nMEMR   = nmemr_q;
  assign nMEMW   = nmemw_q;
  assign nEopOut = neop_q;
  assign WbValid = wb_valid_q;
  assign WbID    = act_id_q;
  assign WbAddr  = tar_q;
  assign WbCount = twc_q;
  assign WbTC    = wb_tc_q;

endmodule

// File: doc/dma_xfer_sequencer.md
# dma_xfer_sequencer

Parametrised next-generation DMA transfer sequencer for the 8237A-style controller. It accepts a granted channel ID from the priority logic, requests the bus, and runs the S0–S4 transfer cycle with a READY wait state, single/block/demand modes and terminal-count/EOP handling. It owns the working address and word-count copies for the active channel and writes them back to the register file when the service ends. It sits between the channel register bank and the system bus interface.

## Interface
- NUM_CH, 4: number of channels, 2..8.
- ADDR_W, 16: address width, multiple of 8, ≥16.
- CNT_W, 16: word-count width.
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-high.
- ReqValid  in  1  granted request present.
- ReqID  in  $clog2(NUM_CH)  granted channel.
- DReq  in  NUM_CH  raw per-channel requests, used for demand mode.
- CurAddr  in  NUM_CH*ADDR_W  current address per channel, channel 0 in the LSBs.
- CurCount  in  NUM_CH*CNT_W  current word count per channel.
- ModeDir  in  2*NUM_CH  transfer type: 00 verify, 01 write to memory, 10 read from memory, 11 illegal (treated as verify).
- ModeXfer  in  2*NUM_CH  transfer mode: 00 demand, 01 single, 10 block, 11 illegal (treated as single).
- ModeDecr  in  NUM_CH  1 = decrement address.
- CmdCompressed  in  1  compressed-timing command bit.
- Hlda  in  1  hold acknowledge.
- Ready  in  1  slow-device ready.
- nEopIn  in  1  external end of process, active-low.
- Hrq  out  1  hold request.
- Aen  out  1  address enable.
- Adstb  out  1  upper address strobe.
- Addr  out  ADDR_W  transfer address.
- nIOR, nIOW, nMEMR, nMEMW  out  1 each  bus strobes, active-low.
- nEopOut  out  1  terminal-count indication, active-low.
- WbValid  out  1  writeback pulse.
- WbID  out  $clog2(NUM_CH)  writeback channel.
- WbAddr  out  ADDR_W  working address value at writeback.
- WbCount  out  CNT_W  working count value at writeback.
- WbTC  out  1  writeback was caused by terminal count.

## Operation
- States: SI, S0, S1, S2, S3, S4. One-hot. All outputs are registered.
- **SI**
  - On ReqValid, latch ReqID into ActID.
  - Load TAR from CurAddr[ActID] and TWC from CurCount[ActID].
  - Next state S0.
- **S0**
  - Hrq=1.
  - Hlda=1 → S1.
  - nEopIn=0 → SI with WbValid, WbTC=0.
- **S1**
  - Aen=1, Adstb=1, Addr=TAR.
  - Next state S2.
- **S2**
  - Aen=1, Addr=TAR.
  - Read strobe asserted: nIOR for type 01, nMEMR for type 10.
  - Next state S3, or S4 if compressed timing is active.
- **S3**
  - Read strobe still asserted; write strobe asserted: nMEMW for type 01, nIOW for type 10.
  - Ready=0 → stay in S3.
  - Ready=1 → S4.
- **Verify type (00):** no strobe is ever asserted; addressing and counting still run.
- **S4**
  - All strobes deasserted.
  - TAR ← TAR±1, modulo 2^ADDR_W.
  - TWC ← TWC−1, modulo 2^CNT_W.
  - TC is true when TWC was 0 on entry to S4; nEopOut=0 for that S4 cycle only.
- **Exit from S4**, first matching rule wins:
  1. TC, or an external EOP latched during S1–S4 → SI with writeback, WbTC=TC.
  2. Single mode → SI with writeback.
  3. Demand mode with DReq[ActID]=0 → SI with writeback.
  4. The next address changes the upper byte (incremented low byte = 00h, or decremented low byte = FFh) → S1.
  5. Otherwise → S2.
- **Hlda drops in S1–S4:** next state SI. All strobes go high and Aen=0 in that same cycle. Writeback uses the unmodified TAR/TWC.

## Timing
- **Reset values:** state SI; Hrq=0, Aen=0, Adstb=0, Addr=0; all four strobes=1; nEopOut=1; WbValid=0, WbTC=0.
- Reset takes effect mid-transfer on the next edge. No writeback is issued.
- ReqValid to Hrq: 1 cycle.
- Hlda to the first Adstb: 1 cycle.
- Cycles per transfer with Ready=1:
  - Normal timing: 4 (S1 S2 S3 S4).
  - Same upper byte: 3 (S2 S3 S4).
  - Compressed timing: 2 (S2 S4).
- WbValid is a 1-cycle pulse in the first SI cycle. WbID, WbAddr, WbCount and WbTC are valid with it.
- ReqValid is ignored while WbValid is high; a new service starts at the earliest on the following cycle.
- External EOP and TC in the same S4: WbTC=1.

## Configuration
- DMA_COMPRESSED_TIMING_EN
  - Defined: CmdCompressed=1 removes S3, so S2 goes directly to S4. Ready is sampled in S2.
  - Not defined: CmdCompressed is ignored and S3 is always visited.

## Structure
- Shared package dma_seq_pkg holds:
  - the state index enum and one-hot state enum;
  - the ModeDir codes: VERIFY, DMA_WRITE, DMA_READ;
  - the ModeXfer codes: DEMAND, SINGLE, BLOCK.
- One sub-module: dma_addr_count_unit. It contains the TAR/TWC registers, increment/decrement, TC detection and upper-byte-change detection.
- The FSM and strobe decode live in the top module.

## Test plan
- **Block write, full timing.** Channel 1: CurAddr=0x10FE, CurCount=2, type 01, block mode, incrementing, Ready=1.
  - Addresses 10FE, 10FF, 1100 (S1 is revisited before 1100).
  - nIOR/nMEMW pulse three times; nEopOut low on the third S4.
  - Writeback: WbAddr=0x1101, WbCount=0xFFFF, WbTC=1.
- **Single mode, decrementing.** Channel 3: CurAddr=0x2000, type 10.
  - One transfer: nMEMR then nIOW.
  - Writeback: WbAddr=0x1FFF, WbCount decremented by 1, WbTC=0; Hrq falls.
- **Demand mode.** DReq[0] is deasserted after the 2nd transfer.
  - Exactly 2 transfers, then writeback with WbTC=0.
- **Wait state.** Ready=0 for 3 cycles while in S3.
  - S3 lasts 4 cycles and strobes stay low throughout.
- **Hlda drop and external EOP.**
  - Hlda drops in S2: strobes go high the next cycle; writeback carries the original CurAddr.
  - nEopIn pulsed in S1: the current transfer completes, then writeback with WbTC=0.
- **Compressed timing** (macro defined, CmdCompressed=1, block mode, same upper byte): 2-cycle transfers, S3 never entered.
